// File: rtl/even_count_display.sv
// even_count_display: binary-to-BCD conversion (sequential double-dabble) feeding
// a time-multiplexed, active-low, common-anode 7-segment display with
// leading-zero blanking. Pure consumer of the upstream counter value.
module even_count_display #(
    parameter int N           = 4,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [N-1:0]        Value,
    output logic [6:0]          Seg,
    output logic [DIGITS-1:0]   An,
    output logic                Dp,
    output logic [4*DIGITS-1:0] Bcd,
    output logic                Busy,
    output logic                Done
);

    localparam int BW = 4 * DIGITS;
    localparam int WW = BW + N;
    localparam int CW = $clog2(N + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADJUST,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   work_q, work_d;
    logic [CW-1:0]   bitcnt_q, bitcnt_d;
    logic [N-1:0]    capt_q, capt_d;
    logic            valid_q, valid_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            done_q, done_d;

    logic [RW-1:0]     refcnt_q, refcnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic [DIGITS-1:0] blank;
    logic [3:0]        cur_nib;
    logic              cur_blank;
    logic              all_zero;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = 7'h7F;
        endcase
    endfunction

    // Conversion FSM and result registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            bitcnt_q <= '0;
            capt_q   <= '0;
            valid_q  <= 1'b0;
            bcd_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            bitcnt_q <= bitcnt_d;
            capt_q   <= capt_d;
            valid_q  <= valid_d;
            bcd_q    <= bcd_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: capture on mismatch, then alternate adjust/shift N times
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        bitcnt_d = bitcnt_q;
        capt_d   = capt_q;
        valid_d  = valid_q;
        bcd_d    = bcd_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!valid_q || (Value != capt_q)) begin
                    capt_d   = Value;
                    work_d   = {{BW{1'b0}}, Value};
                    bitcnt_d = CW'(N);
                    state_d  = S_ADJUST;
                end
            end
            S_ADJUST: begin
                for (int unsigned k = 0; k < DIGITS; k++) begin
                    if (work_q[N+4*k +: 4] >= 4'd5)
                        work_d[N+4*k +: 4] = work_q[N+4*k +: 4] + 4'd3;
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                work_d   = {work_q[WW-2:0], 1'b0};
                bitcnt_d = bitcnt_q - CW'(1);
                state_d  = (bitcnt_q == CW'(1)) ? S_DONE : S_ADJUST;
            end
            S_DONE: begin
                bcd_d   = work_q[WW-1:N];
                valid_d = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Display scan registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            refcnt_q <= '0;
            idx_q    <= '0;
            seg_q    <= 7'h7F;
            an_q     <= '1;
        end else begin
            refcnt_q <= refcnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    // Refresh timing, digit select and leading-zero blanking
    always_comb begin
        refcnt_d  = refcnt_q + RW'(1);
        idx_d     = idx_q;
        blank     = '0;
        all_zero  = 1'b1;
        cur_nib   = 4'd0;
        cur_blank = 1'b0;
        if (refcnt_q == RW'(REFRESH_DIV - 1)) begin
            refcnt_d = '0;
            idx_d    = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        // Walk from the most significant digit down; a digit is blank while
        // it and everything above it are zero (digit 0 always shows).
        for (int unsigned j = 0; j < DIGITS; j++) begin
            all_zero = all_zero && (bcd_q[4*(DIGITS-1-j) +: 4] == 4'd0);
            blank[DIGITS-1-j] = all_zero && (j != DIGITS - 1);
        end
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx_q) begin
                cur_nib   = bcd_q[4*k +: 4];
                cur_blank = blank[k];
            end
        end
        an_d  = ~(DIGITS'(1) << idx_q);
        seg_d = cur_blank ? 7'h7F : glyph(cur_nib);
    end

    assign Seg  = seg_q;
    assign An   = an_q;
    assign Dp   = 1'b1;
    assign Bcd  = bcd_q;
    assign Busy = (state_q != S_IDLE);
    assign Done = done_q;

endmodule
